// File: rtl/alu_flags_reg.sv
// ---------------------------------------------------------------------------
// alu_flags_reg
//
// Architectural flag register sitting between the ALU flag generator and the
// control/branch unit. Holds the 8-bit flag vector, keeps a LIFO save/restore
// stack for interrupt/call entry and exit, and evaluates a 4-bit branch
// condition code against the held flags.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flags_in/_we    ALU flag bus and its update strobe
//   wr_data/wr_en   software flag load
//   push/pop        save / restore flag register on the stack
//   err_clr         clear sticky stack error
//   cond/cond_valid condition evaluation request
//   flags_out       held flag register ([7:6] always 0)
//   take/take_valid registered condition result
//   stk_depth       occupied stack entries
//   stk_full/empty  stack occupancy status
//   stk_err         sticky illegal-stack-operation flag
//
// Handshake: cond_valid is a one-cycle request with no back-pressure; every
// cycle with cond_valid=1 produces exactly one take_valid=1 cycle on the next
// clock, carrying the result evaluated on the flags held in the request cycle.
// take holds its value while take_valid=0.
// ---------------------------------------------------------------------------
module alu_flags_reg #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] flags_in,
    input  logic       flags_we,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       push,
    input  logic       pop,
    input  logic       err_clr,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    output logic [7:0] flags_out,
    output logic       take,
    output logic       take_valid,
    output logic [4:0] stk_depth,
    output logic       stk_full,
    output logic       stk_empty,
    output logic       stk_err
);

    localparam int PW = (STACK_DEPTH <= 2) ? 1 : $clog2(STACK_DEPTH);
    localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

    logic [7:0]    stack_mem [STACK_DEPTH];
    logic          push_ok;
    logic          pop_ok;
    logic          err_now;
    logic [4:0]    depth_next;
    logic [7:0]    flags_next;
    logic [PW-1:0] push_idx;
    logic [PW-1:0] top_idx;
    logic          cond_result;

    // A legal push writes slot [depth]; a legal pop reads slot [depth-1].
    // Both indices only matter when the corresponding operation is legal,
    // so truncation to PW bits is safe.
    assign push_idx = stk_depth[PW-1:0];
    assign top_idx  = PW'(stk_depth - 5'd1);

    // Simultaneous push and pop is illegal, so neither is "ok" in that case.
    assign push_ok = push && !pop && (stk_depth != DEPTH_MAX);
    assign pop_ok  = pop && !push && (stk_depth != 5'd0);
    assign err_now = (push && pop) ||
                     (push && (stk_depth == DEPTH_MAX)) ||
                     (pop  && (stk_depth == 5'd0));

    always_comb begin
        depth_next = stk_depth;
        if (push_ok)
            depth_next = stk_depth + 5'd1;
        else if (pop_ok)
            depth_next = stk_depth - 5'd1;
    end

    // Restore beats software load beats ALU update; reserved bits forced to 0.
    always_comb begin
        flags_next = flags_out;
        if (pop_ok)
            flags_next = stack_mem[top_idx];
        else if (wr_en)
            flags_next = wr_data;
        else if (flags_we)
            flags_next = flags_in;
        flags_next[7:6] = 2'b00;
    end

    // Bits: Z=0, C=1, E=2, L=3, G=4, H=5.
    always_comb begin
        cond_result = 1'b0;
        case (cond)
            4'd0:  cond_result = 1'b1;
            4'd1:  cond_result = flags_out[0];
            4'd2:  cond_result = !flags_out[0];
            4'd3:  cond_result = flags_out[1];
            4'd4:  cond_result = !flags_out[1];
            4'd5:  cond_result = flags_out[2];
            4'd6:  cond_result = !flags_out[2];
            4'd7:  cond_result = flags_out[3];
            4'd8:  cond_result = !flags_out[3];
            4'd9:  cond_result = flags_out[4];
            4'd10: cond_result = !flags_out[4];
            4'd11: cond_result = flags_out[5];
            4'd12: cond_result = !flags_out[5];
            4'd13: cond_result = flags_out[3] | flags_out[2];
            4'd14: cond_result = flags_out[4] | flags_out[2];
            default: cond_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_out  <= 8'h00;
            take       <= 1'b0;
            take_valid <= 1'b0;
            stk_depth  <= 5'd0;
            stk_full   <= 1'b0;
            stk_empty  <= 1'b1;
            stk_err    <= 1'b0;
        end else begin
            flags_out  <= flags_next;
            take_valid <= cond_valid;
            if (cond_valid)
                take <= cond_result;
            stk_depth  <= depth_next;
            stk_full   <= (depth_next == DEPTH_MAX);
            stk_empty  <= (depth_next == 5'd0);
            // A new error wins over a same-cycle clear.
            if (err_now)
                stk_err <= 1'b1;
            else if (err_clr)
                stk_err <= 1'b0;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            stack_mem[push_idx] <= flags_out;
    end

endmodule

// File: tb/tb_alu_flags_reg.sv
module tb_alu_flags_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] flags_in;
    logic       flags_we;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [3:0] cond;
    logic       cond_valid;
    logic [7:0] flags_out;
    logic       take;
    logic       take_valid;
    logic [4:0] stk_depth;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    int total = 0;
    int bad   = 0;
    logic [0:0] exp_q[$];

    alu_flags_reg #(.STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .flags_in(flags_in), .flags_we(flags_we),
        .wr_data(wr_data), .wr_en(wr_en),
        .push(push), .pop(pop), .err_clr(err_clr),
        .cond(cond), .cond_valid(cond_valid),
        .flags_out(flags_out), .take(take), .take_valid(take_valid),
        .stk_depth(stk_depth), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flags_we = 1'b0; wr_en = 1'b0; push = 1'b0; pop = 1'b0;
        err_clr = 1'b0; cond_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " flags_out"},  flags_out, 8'h00);
        chk({tag, " take"},       {7'd0, take}, 8'd0);
        chk({tag, " take_valid"}, {7'd0, take_valid}, 8'd0);
        chk({tag, " stk_depth"},  {3'd0, stk_depth}, 8'd0);
        chk({tag, " stk_empty"},  {7'd0, stk_empty}, 8'd1);
        chk({tag, " stk_full"},   {7'd0, stk_full}, 8'd0);
        chk({tag, " stk_err"},    {7'd0, stk_err}, 8'd0);
    endtask

    // Issue a condition request this cycle and queue the expected result.
    task automatic req(input logic [3:0] c, input logic exp_take);
        cond = c;
        cond_valid = 1'b1;
        exp_q.push_back(exp_take);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (take_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL take_unexpected: take_valid=1 with no pending request");
            end else begin
                logic [0:0] e;
                e = exp_q.pop_front();
                if (take !== e[0]) begin
                    bad++;
                    $display("FAIL take: got %0b expected %0b", take, e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] push_vals [4];
    logic [7:0] sweep_exp;
    logic [15:0] sweep_bits;

    initial begin
        push_vals[0] = 8'h01; push_vals[1] = 8'h02;
        push_vals[2] = 8'h04; push_vals[3] = 8'h08;
        // cond 0..15 with only L set: 1,0,1,0,1,0,1,1,0,0,1,0,1,1,0,0
        sweep_bits = 16'b0011_0100_1101_0101;
        sweep_exp = 8'h00;
        flags_in = 8'h00; wr_data = 8'h00; cond = 4'd0;
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // ALU update with all ones: reserved bits forced to 0.
        flags_we = 1'b1; flags_in = 8'hFF;
        tick(); idle();
        chk("flags_ff_masked", flags_out, 8'h3F);
        req(4'd3, 1'b1);
        tick(); idle();
        tick();

        // wr_en beats flags_we.
        flags_we = 1'b1; flags_in = 8'h01; wr_en = 1'b1; wr_data = 8'h02;
        tick(); idle();
        chk("wr_en_priority", flags_out, 8'h02);
        req(4'd2, 1'b1);
        tick(); idle();

        // No bypass: request in the same cycle as flags_we sees old flags (Z=0).
        flags_we = 1'b1; flags_in = 8'h01;
        req(4'd1, 1'b0);
        tick(); idle();
        chk("flags_we_load", flags_out, 8'h01);
        req(4'd1, 1'b1);
        tick(); idle();

        // Software load of reserved bits only -> zero.
        wr_en = 1'b1; wr_data = 8'hC0;
        tick(); idle();
        chk("wr_reserved_masked", flags_out, 8'h00);

        // Fill the stack.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = push_vals[i];
            tick(); idle();
            push = 1'b1;
            tick(); idle();
        end
        chk("depth_after_fill", {3'd0, stk_depth}, 8'd4);
        chk("full_after_fill", {7'd0, stk_full}, 8'd1);
        chk("err_before_overflow", {7'd0, stk_err}, 8'd0);
        push = 1'b1;
        tick(); idle();
        chk("overflow_depth", {3'd0, stk_depth}, 8'd4);
        chk("overflow_full", {7'd0, stk_full}, 8'd1);
        chk("overflow_err", {7'd0, stk_err}, 8'd1);
        chk("overflow_flags", flags_out, 8'h08);
        err_clr = 1'b1;
        tick(); idle();
        chk("err_clr", {7'd0, stk_err}, 8'd0);

        // Change flags so each restore is visible.
        wr_en = 1'b1; wr_data = 8'h20;
        tick(); idle();
        for (int i = 3; i >= 0; i--) begin
            pop = 1'b1;
            tick(); idle();
            chk($sformatf("pop_%0d", 3 - i), flags_out, push_vals[i]);
        end
        chk("depth_after_drain", {3'd0, stk_depth}, 8'd0);
        chk("empty_after_drain", {7'd0, stk_empty}, 8'd1);
        chk("err_after_drain", {7'd0, stk_err}, 8'd0);

        // Underflow with a concurrent ALU update.
        pop = 1'b1; flags_we = 1'b1; flags_in = 8'h10;
        tick(); idle();
        chk("underflow_err", {7'd0, stk_err}, 8'd1);
        chk("underflow_flags", flags_out, 8'h10);
        chk("underflow_depth", {3'd0, stk_depth}, 8'd0);
        err_clr = 1'b1;
        tick(); idle();
        chk("underflow_clr", {7'd0, stk_err}, 8'd0);
        // New error and clear in the same cycle: error wins.
        pop = 1'b1; err_clr = 1'b1;
        tick(); idle();
        chk("err_beats_clr", {7'd0, stk_err}, 8'd1);
        err_clr = 1'b1;
        tick(); idle();

        // Condition sweep with only L set, back to back.
        wr_en = 1'b1; wr_data = 8'h08;
        tick(); idle();
        for (int c = 0; c < 16; c++) begin
            req(4'(c), sweep_bits[c]);
            tick();
        end
        idle();
        tick();
        tick();
        chk("take_holds", {7'd0, take}, 8'd0);

        // Push with concurrent load saves old value.
        wr_en = 1'b1; wr_data = 8'h20; push = 1'b1;
        tick(); idle();
        chk("push_wr_flags", flags_out, 8'h20);
        push = 1'b1;
        tick(); idle();
        chk("depth_two", {3'd0, stk_depth}, 8'd2);
        push = 1'b1; pop = 1'b1;
        tick(); idle();
        chk("pushpop_depth", {3'd0, stk_depth}, 8'd2);
        chk("pushpop_err", {7'd0, stk_err}, 8'd1);
        chk("pushpop_flags", flags_out, 8'h20);
        err_clr = 1'b1;
        tick(); idle();
        pop = 1'b1;
        tick(); idle();
        chk("pop_after_pushpop", flags_out, 8'h20);
        pop = 1'b1;
        tick(); idle();
        chk("pop_saved_old", flags_out, 8'h08);

        // Reset mid-operation aborts a same-cycle request and stack activity.
        wr_en = 1'b1; wr_data = 8'h04;
        tick(); idle();
        push = 1'b1;
        tick(); idle();
        rst = 1'b1; cond = 4'd0; cond_valid = 1'b1; push = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3F;
        tick(); idle();
        chk_reset_state("mid_reset");
        tick();
        chk("reset_no_take", {7'd0, take_valid}, 8'd0);

        tick(); tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL take_missing: %0d results outstanding expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish expected done");
        $fatal(1);
    end

endmodule
